// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector: FSM encoding, default width
// and the Q8.8 saturation limits.
package psum_collector_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned DataWDefault = 16;

  // Q8.8 clamp limits for the default 16-bit psum.
  localparam logic [15:0] PSUM_MAX = 16'h7FFF;
  localparam logic [15:0] PSUM_MIN = 16'h8000;

endpackage

// File: rtl/psum_collector_sat_adder.sv
// Combinational signed saturating adder. The sum clamps to the most positive or
// most negative representable value, and clamp_o flags that a clamp happened.
module sat_adder
  import psum_collector_pkg::*;
#(
  parameter int unsigned W = DataWDefault
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         clamp_o
);

  logic [W-1:0] max_val;
  logic [W-1:0] min_val;
  logic [W:0]   sum_ext;
  logic         ovf_pos;
  logic         ovf_neg;

  if (W == 16) begin : g_q88
    assign max_val = PSUM_MAX;
    assign min_val = PSUM_MIN;
  end else begin : g_generic
    assign max_val = {1'b0, {(W-1){1'b1}}};
    assign min_val = {1'b1, {(W-1){1'b0}}};
  end

  // Add with one guard bit; the guard and sign bits disagree exactly on overflow.
  always_comb begin
    sum_ext = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    ovf_pos = ~sum_ext[W] & sum_ext[W-1];
    ovf_neg = sum_ext[W] & ~sum_ext[W-1];
    clamp_o = ovf_pos | ovf_neg;
    if (ovf_pos) begin
      sum_o = max_val;
    end else if (ovf_neg) begin
      sum_o = min_val;
    end else begin
      sum_o = sum_ext[W-1:0];
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: accumulates num_pass rows of DEPTH psums from a PE
// column into a register buffer with saturating adds, then drains the row.
// Optional feature: define PSUM_COLLECTOR_RELU_EN to apply ReLU on drain.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        num_pass_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_psum_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              sat_o
);

  localparam int unsigned   IdxW    = $clog2(DEPTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
  logic [3:0]        pass_cnt_q, pass_cnt_d;
  logic [3:0]        pass_max_q, pass_max_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] buf_q [DEPTH];

  logic              in_xfer;
  logic              row_wrap;
  logic              last_pass;
  logic              first_pass;
  logic [DATA_W-1:0] add_sum;
  logic              add_clamp;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] drain_val;

  sat_adder #(
    .W (DATA_W)
  ) u_sat_adder (
    .a_i     (buf_q[idx_q]),
    .b_i     (in_psum_i),
    .sum_o   (add_sum),
    .clamp_o (add_clamp)
  );

  // Datapath decode: transfer qualification, row/pass boundaries, drain value.
  always_comb begin
    in_ready_o = (state_q == StAccum);
    in_xfer    = in_valid_i & in_ready_o;
    row_wrap   = (idx_q == IdxLast);
    last_pass  = (pass_cnt_q == (pass_max_q - 4'd1));
    first_pass = (pass_cnt_q == 4'd0);
    wr_data    = first_pass ? in_psum_i : add_sum;
    rd_data    = buf_q[rd_idx_q];
`ifdef PSUM_COLLECTOR_RELU_EN
    drain_val  = rd_data[DATA_W-1] ? '0 : rd_data;
`else
    drain_val  = rd_data;
`endif
  end

  // Next-state and output logic for the IDLE/ACCUM/DRAIN controller.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    pass_cnt_d  = pass_cnt_q;
    pass_max_d  = pass_max_q;
    sat_d       = sat_q;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    busy_o      = (state_q != StIdle);
    sat_o       = sat_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StAccum;
          pass_max_d = (num_pass_i == 4'd0) ? 4'd1 : num_pass_i;
          pass_cnt_d = 4'd0;
          idx_d      = '0;
          sat_d      = 1'b0;
        end
      end
      StAccum: begin
        if (in_xfer) begin
          idx_d = idx_q + 1'b1;
          // Pass 0 overwrites, so its clamp output is meaningless.
          if (!first_pass && add_clamp) begin
            sat_d = 1'b1;
          end
          if (row_wrap) begin
            if (last_pass) begin
              state_d    = StDrain;
              rd_idx_d   = '0;
              pass_cnt_d = 4'd0;
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end
        end
      end
      StDrain: begin
        out_valid_o = 1'b1;
        out_data_o  = drain_val;
        out_last_o  = (rd_idx_q == IdxLast);
        if (out_ready_i) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == IdxLast) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      pass_cnt_q <= 4'd0;
      pass_max_q <= 4'd1;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      pass_cnt_q <= pass_cnt_d;
      pass_max_q <= pass_max_d;
      sat_q      <= sat_d;
    end
  end

  // Row buffer: one write port; left uncleared since pass 0 overwrites it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && in_xfer) begin
      buf_q[idx_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector (DATA_W=16, DEPTH=8) with a scoreboard
// of expected drain outputs. Honours PSUM_COLLECTOR_RELU_EN for expectations.
module tb_psum_collector;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  num_pass;
  logic        in_valid;
  logic [15:0] in_psum;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        sat;

  int          n_total = 0;
  int          n_bad   = 0;
  exp_t        exp_q[$];
  logic [15:0] stim [16][8];
  logic        hold_pending = 1'b0;
  logic [15:0] held_data    = '0;

  psum_collector #(
    .DATA_W (16),
    .DEPTH  (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .num_pass_i  (num_pass),
    .in_valid_i  (in_valid),
    .in_psum_i   (in_psum),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .sat_o       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] f_out(input logic [15:0] x);
`ifdef PSUM_COLLECTOR_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  // Reference saturating add on plain integers.
  function automatic logic [16:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard compare on every output transfer, hold check on stalls.
  always @(negedge clk) begin
    if (hold_pending && !rst) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, out_data}, {16'd0, held_data});
    end
    hold_pending <= out_valid && !out_ready && !rst;
    held_data    <= out_data;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        check("out_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
        check("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
        void'(exp_q.pop_front());
      end
      check("in_ready_drain", {31'd0, in_ready}, 32'd0);
    end
  end

  // One complete job; stall=1 applies the 1,0,0,1 out_ready pattern plus junk
  // start/in_valid during drain, gaps=1 inserts idle input cycles.
  task automatic run_job(input int np, input bit stall, input bit gaps);
    int          npe;
    int          cyc;
    logic [15:0] mbuf [8];
    logic [16:0] r;
    bit          msat;
    npe  = (np == 0) ? 1 : np;
    msat = 1'b0;
    num_pass = np[3:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < npe; p++) begin
      for (int i = 0; i < 8; i++) begin
        if (gaps && (i % 3 == 1)) begin
          in_valid = 1'b0;
          in_psum  = 16'hDEAD;
          tick();
        end
        in_valid = 1'b1;
        in_psum  = stim[p][i];
        if (p == 0 && i == 0) begin
          @(negedge clk);
          check("in_ready_accum", {31'd0, in_ready}, 32'd1);
          check("busy_accum", {31'd0, busy}, 32'd1);
          @(posedge clk);
          #1;
        end else begin
          tick();
        end
        if (p == 0) begin
          mbuf[i] = stim[p][i];
        end else begin
          r       = m_add(mbuf[i], stim[p][i]);
          mbuf[i] = r[15:0];
          msat    = msat | r[16];
        end
      end
    end
    in_valid  = stall;
    in_psum   = 16'h1234;
    start     = stall;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({f_out(mbuf[i]), (i == 7)});
    @(negedge clk);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("in_ready_drain0", {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (busy && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (stall) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
    if (busy) check("drain_timeout", 32'd0, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_idle", {31'd0, out_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sat", {31'd0, sat}, {31'd0, msat});
    check("sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_pass = 4'd0; in_valid = 1'b0;
    in_psum = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);

    // Single pass ramp 1.0 .. 8.0.
    for (int i = 0; i < 8; i++) stim[0][i] = 16'(16'h0100 * (i + 1));
    run_job(1, 1'b0, 1'b0);

    // Three passes of 1.0 with input bubbles.
    for (int p = 0; p < 3; p++) for (int i = 0; i < 8; i++) stim[p][i] = 16'h0100;
    run_job(3, 1'b0, 1'b1);

    // Positive and negative saturation.
    for (int i = 0; i < 8; i++) begin
      stim[0][i] = 16'(16'h0010 * i);
      stim[1][i] = 16'h0001;
    end
    stim[0][0] = 16'h7F00; stim[1][0] = 16'h0200;
    stim[0][1] = 16'h8100; stim[1][1] = 16'hFE00;
    run_job(2, 1'b0, 1'b0);
    in_valid = 1'b1; in_psum = 16'h5555;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_sticky_idle", {31'd0, sat}, 32'd1);

    // Negative outputs (ReLU dependent).
    for (int i = 0; i < 8; i++) stim[0][i] = 16'hFF00;
    run_job(1, 1'b0, 1'b0);

    // num_pass=0 acts as 1; drain with stalls and ignored start/in_valid.
    for (int i = 0; i < 8; i++) stim[0][i] = 16'(16'h0333 * i - 16'h0800);
    run_job(0, 1'b1, 1'b0);

    // Reset after 5 transfers of a pass.
    for (int p = 0; p < 2; p++) for (int i = 0; i < 8; i++) stim[p][i] = 16'h7000;
    num_pass = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_psum = stim[0][i];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int p = 0; p < 2; p++) for (int i = 0; i < 8; i++) stim[p][i] = 16'(16'h0011 * (i + p));
    run_job(2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter DATA_W, default 16: psum width, signed Q8.8 fixed point.
REQ-002 Parameter DEPTH, default 8: psums per pass (one output row); a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse in IDLE; latches num_pass and begins a job.
REQ-006 num_pass  input  4  passes per job (input channels); the value 0 is treated as 1.
REQ-007 in_valid  input  1  in_psum is valid this cycle.
REQ-008 in_psum  input  DATA_W  partial sum from the top of a PE column (the PE out_sum chain).
REQ-009 in_ready  output  1  collector accepts in_psum this cycle.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_data  output  DATA_W  final accumulated (and optionally rectified) psum.
REQ-012 out_last  output  1  marks the DEPTH-th output of a job.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 sat  output  1  sticky flag: saturation occurred in the current job.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, ACCUM and DRAIN.
REQ-017 IDLE->ACCUM on start; num_pass latched into pass_max, pass_cnt=0, idx=0, sat cleared.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 in_ready=1 only in ACCUM; an input transfer occurs when in_valid and in_ready are both high.
REQ-020 On a transfer with pass_cnt=0, buf[idx] <= in_psum (overwrite).
REQ-021 On a transfer with pass_cnt>0, buf[idx] <= sat_add(buf[idx], in_psum).
REQ-022 sat_add: signed DATA_W add clamped to 0x7FFF / 0x8000; any clamp sets sat.
REQ-023 idx increments per transfer; idx=DEPTH-1 wraps to 0 and increments pass_cnt.
REQ-024 Transfer at idx=DEPTH-1 with pass_cnt=pass_max-1: ACCUM->DRAIN next cycle, rd_idx=0.
REQ-025 DRAIN: out_valid=1; out_data=f(buf[rd_idx]); out_last=(rd_idx==DEPTH-1).
REQ-026 An output transfer (out_valid & out_ready) advances rd_idx.
REQ-027 Output transfer with out_last: DRAIN->IDLE; out_valid low the next cycle.
REQ-028 out_data/out_valid/out_last SHALL hold stable while out_valid & !out_ready.
REQ-029 Latency: first out_valid one cycle after the final input transfer; one output per cycle under continuous out_ready.
REQ-030 in_valid outside ACCUM SHALL be ignored; no buffer change.
REQ-031 sat SHALL remain readable in IDLE until the next start.

Reset
REQ-032 rst SHALL force IDLE, with in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, sat=0, and idx, rd_idx and pass_cnt all 0.
REQ-033 rst SHALL override every other input in the same cycle, including mid-ACCUM and mid-DRAIN; the partial job is discarded.
REQ-034 Buffer contents need not be cleared by reset, because pass 0 overwrites them.

Configuration
REQ-035 Macro PSUM_COLLECTOR_RELU_EN defined: f(x)=0 when x is negative, otherwise x (ReLU on drain).
REQ-036 Macro PSUM_COLLECTOR_RELU_EN undefined: f(x)=x; accumulation and sat behaviour are unchanged in both cases.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the DATA_W default, and the Q8.8 saturation limits PSUM_MAX=16'h7FFF and PSUM_MIN=16'h8000.
REQ-038 A sub-module sat_adder SHALL implement the combinational saturating add and output the clamp flag.
REQ-039 The buffer SHALL be a register array of DEPTH x DATA_W, with one write port and one read port.

Verification
REQ-040 Scenario: num_pass=1, inputs 1..8 (Q8.8 0x0100*k), out_ready=1 -> outputs 0x0100..0x0800 in order, out_last on the 8th, sat=0.
REQ-041 Scenario: num_pass=3, every input 0x0100 -> each output 0x0300; first out_valid one cycle after the 24th transfer.
REQ-042 Scenario: num_pass=2, buf entry 0x7F00 plus input 0x0200 -> that output 0x7FFF and sat=1; second, 0x8100 plus 0xFE00 -> 0x8000.
REQ-043 Scenario: num_pass=1, inputs of -0x0100 -> outputs 0x0000 with RELU_EN, 0xFF00 without it.
REQ-044 Scenario: out_ready toggled 1,0,0,1 during DRAIN -> out_data stable across the stalls; no duplicated or lost outputs; in_ready=0 throughout.
REQ-045 Scenario: rst asserted after 5 transfers of a pass -> the next cycle shows IDLE, busy=0, out_valid=0; a new start then produces correct results with no residue.
